// File: rtl/pc_gen_if.sv
// Request/result bundle between the fetch-stage control and the PC generator.
// The master issues stall/redirect requests. The slave returns the registered fetch PC state.
interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            trap;
  logic [XLEN-1:0] trap_vector;
  logic            branch_jal;
  logic [XLEN-1:0] branch_jump_address;
  logic            jalr;
  logic [XLEN-1:0] jalr_address;
  logic [XLEN-1:0] address_out;
  logic [XLEN-1:0] prev_address;
  logic            redirect_taken;
  logic            misaligned;

  modport master (
    output stall, trap, trap_vector, branch_jal, branch_jump_address, jalr, jalr_address,
    input  address_out, prev_address, redirect_taken, misaligned
  );

  modport slave (
    input  stall, trap, trap_vector, branch_jal, branch_jump_address, jalr, jalr_address,
    output address_out, prev_address, redirect_taken, misaligned
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch-stage program counter: trap > branch/JAL > JALR > sequential priority.
// A redirect seen during a stall is parked in a pending register and applied on release.
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INCR         = 4   // 2 or 4
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.slave  bus
);

  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INCR - 1);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_prev;
  logic            r_redirect_taken;
  logic            r_misaligned;
  logic            r_pend_valid;
  logic [XLEN-1:0] r_pend_target;
  logic            r_pend_mis;

  logic [XLEN-1:0] w_jalr_target;
  logic            w_live_valid;
  logic [XLEN-1:0] w_live_target;
  logic            w_live_mis;
  logic [XLEN-1:0] w_next_pc;
  logic            w_next_redirect;
  logic            w_next_mis;

  assign w_jalr_target = bus.jalr_address & ~XLEN'(1);

  // Winning live redirect. Targets are stored already aligned; the flag records if alignment was forced.
  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    w_live_valid  = 1'b0;
    w_live_target = '0;
    w_live_mis    = 1'b0;
    if (bus.trap) begin
      w_live_valid  = 1'b1;
      w_live_target = bus.trap_vector;
    end else if (bus.branch_jal) begin
      w_live_valid  = 1'b1;
      w_live_target = bus.branch_jump_address & ~LOW_MASK;
      w_live_mis    = |(bus.branch_jump_address & LOW_MASK);
    end else if (bus.jalr) begin
      w_live_valid  = 1'b1;
      w_live_target = w_jalr_target & ~LOW_MASK;
      w_live_mis    = |(w_jalr_target & LOW_MASK);
    end
  end

  // A live trap beats a parked redirect; a parked redirect beats a live branch/JALR.
  always_comb begin
    w_next_pc       = r_pc + XLEN'(INCR);
    w_next_redirect = 1'b0;
    w_next_mis      = 1'b0;
    if (bus.trap) begin
      w_next_pc       = w_live_target;
      w_next_redirect = 1'b1;
    end else if (r_pend_valid) begin
      w_next_pc       = r_pend_target;
      w_next_redirect = 1'b1;
      w_next_mis      = r_pend_mis;
    end else if (w_live_valid) begin
      w_next_pc       = w_live_target;
      w_next_redirect = 1'b1;
      w_next_mis      = w_live_mis;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc             <= RESET_VECTOR;
      r_prev           <= RESET_VECTOR;
      r_redirect_taken <= 1'b0;
      r_misaligned     <= 1'b0;
      r_pend_valid     <= 1'b0;
      r_pend_target    <= '0;
      r_pend_mis       <= 1'b0;
    end else if (bus.stall) begin
      r_redirect_taken <= 1'b0;
      r_misaligned     <= 1'b0;
      // Oldest non-trap redirect is kept; only a trap may overwrite it.
      if (w_live_valid && (!r_pend_valid || bus.trap)) begin
        r_pend_valid  <= 1'b1;
        r_pend_target <= w_live_target;
        r_pend_mis    <= w_live_mis;
      end
    end else begin
      r_pc             <= w_next_pc;
      r_prev           <= r_pc;
      r_redirect_taken <= w_next_redirect;
      r_misaligned     <= w_next_mis;
      r_pend_valid     <= 1'b0;
    end
  end

  assign bus.address_out    = r_pc;
  assign bus.prev_address   = r_prev;
  assign bus.redirect_taken = r_redirect_taken;
  assign bus.misaligned     = r_misaligned;

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the rv32i pipeline fetch stage, successor to the original fixed-width PC register. It selects the next fetch address from sequential increment, branch/JAL, JALR and trap redirects under a fixed priority. It holds the PC on a fetch stall and latches a redirect that arrives during a stall so the redirect is not lost. It also reports misaligned redirect targets and pulses a flush indication to the fetch/decode stages.

## Interface

Parameters:
- XLEN, 32, address width in bits.
- RESET_VECTOR, 0, value loaded into `address_out` and `prev_address` on reset.
- INCR, 4, sequential increment in bytes. Must be 2 or 4.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold the PC (replaces the old `load & !valid` term).
- trap  input  1  trap redirect request.
- trap_vector  input  XLEN  trap target.
- branch_jal  input  1  taken branch or JAL redirect.
- branch_jump_address  input  XLEN  branch/JAL target.
- jalr  input  1  JALR redirect.
- jalr_address  input  XLEN  JALR target, before bit-0 clear.
- address_out  output  XLEN  current fetch address.
- prev_address  output  XLEN  address fetched in the previous accepted cycle.
- redirect_taken  output  1  one-cycle pulse when `address_out` was loaded from a redirect.
- misaligned  output  1  one-cycle pulse when the applied redirect target was misaligned.

## Operation

- **Target formation.**
  - JALR target = `jalr_address & ~1`.
  - A target is misaligned if `target % INCR != 0` after the bit-0 clear. With INCR=4 this means bit 1 is set.
  - A misaligned target is still loaded, with the low `log2(INCR)` bits cleared, and `misaligned` is pulsed.
  - `trap_vector` is never checked for alignment.
- **Live priority.** Among same-cycle requests: trap > branch_jal > jalr > sequential.
- **Pending redirect register.** Holds `pend_valid`, `pend_target` and `pend_mis`.
  - When `stall`=1 and any redirect is asserted, the winning redirect is captured into the pending register, subject to the capture rules below.
  - Capture if `pend_valid`=0.
  - Capture if the live request is a trap. A trap overwrites any pending branch/JAL/JALR.
  - Otherwise the existing pending entry is kept. The oldest non-trap redirect wins.
- **Next-PC selection when `stall`=0:**
  1. A live trap loads `trap_vector`.
  2. Otherwise, if `pend_valid`=1, load `pend_target`.
  3. Otherwise, a live branch_jal or jalr loads its target.
  4. Otherwise, load `address_out + INCR`, wrapping modulo 2^XLEN.
- **Pending clear.** `pend_valid` clears on any cycle with `stall`=0, whether or not the pending target was used.
- **Stall hold.** When `stall`=1, `address_out` and `prev_address` hold their values. Redirects are captured only; they are not applied.
- **prev_address.** When `stall`=0, `prev_address` takes the old `address_out` on every update, including redirects.
- **redirect_taken.** Registered. It is 1 in the cycle after an unstalled update that came from a trap, a pending entry or a live redirect.
- **misaligned.** Registered. It is 1 together with `redirect_taken` when the applied target was flagged misaligned. The flag comes from `pend_mis` when the pending entry is used.

## Timing

- **Reset.** `rst`=1 at a rising edge gives:
  - `address_out` = RESET_VECTOR and `prev_address` = RESET_VECTOR.
  - `redirect_taken` = 0, `misaligned` = 0, `pend_valid` = 0.
  - Reset overrides `stall` and all redirects in the same cycle.
  - Reset mid-stall discards any pending redirect.
- **Latency.** A redirect with `stall`=0 at edge N makes `address_out` equal the target after edge N, with `redirect_taken`=1 in that same cycle.
- **Stall release.** A pending redirect is applied at the first edge with `stall`=0. There are no extra bubble cycles.
- **Outputs.** All outputs are registered. There is no combinational path from inputs to outputs.
- **Wrap-around.** `address_out` = 2^XLEN − INCR, unstalled and with no redirect, becomes 0.

## Test plan

- **Reset and sequential fetch.** Hold `rst` for 2 cycles, then release with no stall or redirect. Required: `address_out` runs 0, 4, 8, 12 and `prev_address` runs 0, 0, 4, 8. `redirect_taken` stays 0.
- **Priority.** At PC=0x10, assert trap (vector 0x100), branch_jal (0x40) and jalr (0x80) together. Required: next PC=0x100, `prev_address`=0x10, `redirect_taken` pulses 1 for one cycle.
- **Redirect during stall.**
  - At PC=0x20 with `stall`=1, assert branch_jal to 0x200. Hold the stall 3 cycles, with jalr to 0x300 in the second stalled cycle.
  - Required: PC holds 0x20 throughout the stall. On release, PC=0x200 (the oldest entry wins) and `redirect_taken`=1.
  - Repeat with a trap to 0x100 in the second stalled cycle. Required: 0x100 after release.
- **Misalignment.**
  - jalr with `jalr_address`=0x1007. Required: PC=0x1004 and `misaligned`=1.
  - jalr with `jalr_address`=0x1005. Required: PC=0x1004 and `misaligned`=0.
  - branch_jal to 0x2002 with INCR=2. Required: PC=0x2002 and `misaligned`=0.
- **Wrap-around.** Force PC to 0xFFFF_FFFC, run unstalled. Required: next PC=0 and `prev_address`=0xFFFF_FFFC.
- **Reset mid-stall.** Stall, capture branch_jal to 0x400, then assert `rst` while still stalled and release both. Required: PC=RESET_VECTOR and no redirect to 0x400 ever occurs.
